traffic_conflict_monitor: RTL and testbench

- Downstream stage of the traffic light controller.
- Registers the six lamp requests (ns/ew green/yellow/red) and checks them every cycle for unsafe combinations.
- Drives the physical lamp outputs.
- On a persistent fault it latches a fault code and forces the intersection into flashing all-red until a qualified clear.

---
 rtl/traffic_conflict_monitor_if.sv | 37 +++
 rtl/traffic_conflict_monitor.sv | 183 ++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp request/drive bundle between the light controller and the conflict monitor.
// The controller side uses the master modport; the monitor uses slave.
interface traffic_conflict_monitor_if;
  logic       ns_green_i;
  logic       ns_yellow_i;
  logic       ns_red_i;
  logic       ew_green_i;
  logic       ew_yellow_i;
  logic       ew_red_i;
  logic       fault_clr;
  logic       ns_green_o;
  logic       ns_yellow_o;
  logic       ns_red_o;
  logic       ew_green_o;
  logic       ew_yellow_o;
  logic       ew_red_o;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output ns_green_i, ns_yellow_i, ns_red_i,
    output ew_green_i, ew_yellow_i, ew_red_i,
    output fault_clr,
    input  ns_green_o, ns_yellow_o, ns_red_o,
    input  ew_green_o, ew_yellow_o, ew_red_o,
    input  fault, fault_code
  );

  modport slave (
    input  ns_green_i, ns_yellow_i, ns_red_i,
    input  ew_green_i, ew_yellow_i, ew_red_i,
    input  fault_clr,
    output ns_green_o, ns_yellow_o, ns_red_o,
    output ew_green_o, ew_yellow_o, ew_red_o,
    output fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Lamp safety monitor: registers lamp requests, detects unsafe combinations and forces all-red.
// Define TCM_FLASH_EN to make the reds flash while in FAULT (solid red otherwise).
module traffic_conflict_monitor #(
  parameter int unsigned PERSIST      = 3,
  parameter int unsigned MIN_YELLOW   = 4,
  parameter int unsigned FLASH_HALF   = 8,
  parameter int unsigned MIN_FAULT    = 32,
  parameter int unsigned RECOVER_TIME = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  traffic_conflict_monitor_if.slave   bus
);

  localparam logic [3:0] PersistMax  = 4'(PERSIST);
  localparam logic [3:0] PersistM1   = 4'(PERSIST - 1);
  localparam logic [7:0] MinYellow   = 8'(MIN_YELLOW);
  localparam logic [9:0] MinFault    = 10'(MIN_FAULT);
  localparam logic [7:0] RecoverTime = 8'(RECOVER_TIME);
  localparam logic [5:0] AllRed      = 6'b001_001;

  typedef enum logic [1:0] {StMonitor, StFault, StRecover} state_e;

  state_e     state_q, state_d;
  // Per direction: [2] green, [1] yellow, [0] red
  logic [2:0] r_ns_q, r_ew_q;
  logic [3:0] persist_q, persist_d;
  logic [7:0] ns_ycnt_q, ns_ycnt_d, ew_ycnt_q, ew_ycnt_d;
  logic [9:0] timer_q, timer_d;
  logic [7:0] rec_q, rec_d;
  logic [2:0] code_q, code_d;
  logic [5:0] lamp_q, lamp_d;
  logic       conflict, multi, dark, illegal, all_red;
  logic       persist_hit, short_yellow, fault_det;
  logic [2:0] det_code;
  logic       flash_restart, red_fault;

  function automatic logic multi_lit(input logic [2:0] l);
    return (l[2] & l[1]) | (l[2] & l[0]) | (l[1] & l[0]);
  endfunction

  always_comb begin
    conflict = (r_ns_q[2] | r_ns_q[1]) & (r_ew_q[2] | r_ew_q[1]);
    multi    = multi_lit(r_ns_q) | multi_lit(r_ew_q);
    dark     = (r_ns_q == 3'b000) | (r_ew_q == 3'b000);
    illegal  = conflict | multi | dark;
    all_red  = (r_ns_q == 3'b001) && (r_ew_q == 3'b001);

    // Fires on the cycle the count would reach PERSIST, so the fault lands one edge later
    persist_hit = illegal && (persist_q >= PersistM1);
    persist_d   = '0;
    if (illegal) persist_d = (persist_q == PersistMax) ? persist_q : persist_q + 4'd1;

    ns_ycnt_d = '0;
    ew_ycnt_d = '0;
    if (r_ns_q[1]) ns_ycnt_d = (ns_ycnt_q == 8'hff) ? ns_ycnt_q : ns_ycnt_q + 8'd1;
    if (r_ew_q[1]) ew_ycnt_d = (ew_ycnt_q == 8'hff) ? ew_ycnt_q : ew_ycnt_q + 8'd1;
    // Non-zero count with yellow now off marks the falling edge
    short_yellow = (!r_ns_q[1] && ns_ycnt_q != 8'd0 && ns_ycnt_q < MinYellow) ||
                   (!r_ew_q[1] && ew_ycnt_q != 8'd0 && ew_ycnt_q < MinYellow);

    fault_det = persist_hit | short_yellow;
    if (persist_hit) begin
      if (conflict)   det_code = 3'd1;
      else if (multi) det_code = 3'd2;
      else            det_code = 3'd3;
    end else begin
      det_code = 3'd4;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rec_d         = rec_q;
    code_d        = code_q;
    flash_restart = 1'b0;
    case (state_q)
      StMonitor: begin
        if (fault_det) begin
          state_d       = StFault;
          code_d        = det_code;
          timer_d       = '0;
          flash_restart = 1'b1;
        end
      end
      StFault: begin
        timer_d = (timer_q == MinFault) ? timer_q : timer_q + 10'd1;
        if (bus.fault_clr && timer_q == MinFault && all_red) begin
          state_d = StRecover;
          rec_d   = RecoverTime;
        end
      end
      default: begin
        if (illegal) begin
          rec_d = RecoverTime;
        end else if (rec_q <= 8'd1) begin
          state_d = StMonitor;
          code_d  = 3'd0;
        end else begin
          rec_d = rec_q - 8'd1;
        end
      end
    endcase
  end

`ifdef TCM_FLASH_EN
  localparam logic [7:0] FlashHalfM1 = 8'(FLASH_HALF - 1);
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    if (flash_restart) begin
      flash_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (state_q == StFault) begin
      if (flash_cnt_q == FlashHalfM1) begin
        flash_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
      end
    end
    red_fault = phase_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flash_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  assign red_fault = 1'b1;
`endif

  // Drives are registered from the next state so greens drop on the same edge FAULT is entered
  always_comb begin
    lamp_d = AllRed;
    case (state_d)
      StMonitor: lamp_d = {r_ns_q, r_ew_q};
      StFault:   lamp_d = {2'b00, red_fault, 2'b00, red_fault};
      default:   lamp_d = AllRed;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StRecover;
      r_ns_q    <= '0;
      r_ew_q    <= '0;
      persist_q <= '0;
      ns_ycnt_q <= '0;
      ew_ycnt_q <= '0;
      timer_q   <= '0;
      rec_q     <= RecoverTime;
      code_q    <= '0;
      lamp_q    <= AllRed;
    end else begin
      state_q   <= state_d;
      r_ns_q    <= {bus.ns_green_i, bus.ns_yellow_i, bus.ns_red_i};
      r_ew_q    <= {bus.ew_green_i, bus.ew_yellow_i, bus.ew_red_i};
      persist_q <= persist_d;
      ns_ycnt_q <= ns_ycnt_d;
      ew_ycnt_q <= ew_ycnt_d;
      timer_q   <= timer_d;
      rec_q     <= rec_d;
      code_q    <= code_d;
      lamp_q    <= lamp_d;
    end
  end

  assign {bus.ns_green_o, bus.ns_yellow_o, bus.ns_red_o} = lamp_q[5:3];
  assign {bus.ew_green_o, bus.ew_yellow_o, bus.ew_red_o} = lamp_q[2:0];
  assign bus.fault      = (state_q != StMonitor);
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with hand-computed expectations.
module tb_traffic_conflict_monitor;

  localparam logic [5:0] AllRed   = 6'b001_001;
  localparam logic [5:0] GoMask   = 6'b110_110;
`ifdef TCM_FLASH_EN
  localparam logic [5:0] FlashOff = 6'b000_000;
`else
  localparam logic [5:0] FlashOff = 6'b001_001;
`endif
  // {ns g,y,r, ew g,y,r}: NS green/yellow(4)/red, then EW green/yellow(4)/red
  localparam logic [5:0] NormSeq [17] = '{
    6'b100_001, 6'b100_001, 6'b100_001,
    6'b010_001, 6'b010_001, 6'b010_001, 6'b010_001,
    6'b001_001, 6'b001_001,
    6'b001_100, 6'b001_100,
    6'b001_010, 6'b001_010, 6'b001_010, 6'b001_010,
    6'b001_001, 6'b001_001
  };

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .PERSIST      (3),
    .MIN_YELLOW   (4),
    .FLASH_HALF   (8),
    .MIN_FAULT    (32),
    .RECOVER_TIME (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [2:0] ns, input logic [2:0] ew);
    {bus.ns_green_i, bus.ns_yellow_i, bus.ns_red_i} = ns;
    {bus.ew_green_i, bus.ew_yellow_i, bus.ew_red_i} = ew;
  endtask

  function automatic logic [5:0] lamps();
    return {bus.ns_green_o, bus.ns_yellow_o, bus.ns_red_o,
            bus.ew_green_o, bus.ew_yellow_o, bus.ew_red_o};
  endfunction

  // Asynchronous reset between clock edges, then run RECOVER out with all-red inputs
  task automatic do_reset(input string tag);
    set_in(3'b001, 3'b001);
    resetn = 1'b0;
    #2;
    check_eq({tag, "_rst_lamps"}, 32'(lamps()), 32'(AllRed));
    check_eq({tag, "_rst_fault"}, 32'(bus.fault), 32'd1);
    check_eq({tag, "_rst_code"}, 32'(bus.fault_code), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick(4);
    check_eq({tag, "_recover_hold"}, 32'(bus.fault), 32'd1);
    tick(1);
    check_eq({tag, "_monitor"}, 32'(bus.fault), 32'd0);
  endtask

  // Hold an illegal pattern for exactly PERSIST input cycles, then go all-red
  task automatic fault_case(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                            input logic [2:0] exp_code);
    set_in(ns, ew);
    tick(3);
    check_eq({tag, "_pending"}, 32'(bus.fault), 32'd0);
    set_in(3'b001, 3'b001);
    tick(1);
    check_eq({tag, "_fault"}, 32'(bus.fault), 32'd1);
    check_eq({tag, "_code"}, 32'(bus.fault_code), 32'(exp_code));
    check_eq({tag, "_go_off"}, 32'(lamps() & GoMask), 32'd0);
  endtask

  initial begin
    logic [5:0] prev;
    bus.fault_clr = 1'b0;
    set_in(3'b001, 3'b001);
    #1;
    do_reset("init");

    // Pass-through with two cycles of latency
    prev = AllRed;
    for (int i = 0; i < 17; i++) begin
      set_in(NormSeq[i][5:3], NormSeq[i][2:0]);
      tick(1);
      check_eq($sformatf("norm_lamps_%0d", i), 32'(lamps()), 32'(prev));
      prev = NormSeq[i];
    end
    check_eq("norm_no_fault", 32'(bus.fault), 32'd0);

    // Two-cycle conflict glitch is tolerated
    set_in(3'b100, 3'b100);
    tick(2);
    set_in(3'b001, 3'b001);
    tick(3);
    check_eq("glitch_no_fault", 32'(bus.fault), 32'd0);

    fault_case("conflict", 3'b100, 3'b100, 3'd1);

    // FAULT entered on the last edge (cycle 0)
    tick(7);
    check_eq("flash_on", 32'(lamps()), 32'(AllRed));
    tick(1);
    check_eq("flash_off", 32'(lamps()), 32'(FlashOff));
    tick(2);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check_eq("clr_early_ignored", 32'(bus.fault), 32'd1);
    set_in(3'b100, 3'b001);
    tick(28);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check_eq("clr_green_ignored", 32'(bus.fault), 32'd1);
    check_eq("clr_green_go_off", 32'(lamps() & GoMask), 32'd0);
    check_eq("clr_green_code", 32'(bus.fault_code), 32'd1);
    set_in(3'b001, 3'b001);
    tick(1);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check_eq("recover_fault", 32'(bus.fault), 32'd1);
    check_eq("recover_code_held", 32'(bus.fault_code), 32'd1);
    check_eq("recover_lamps", 32'(lamps()), 32'(AllRed));
    tick(3);
    check_eq("recover_still", 32'(bus.fault), 32'd1);
    tick(1);
    check_eq("recover_done", 32'(bus.fault), 32'd0);
    check_eq("recover_code_clr", 32'(bus.fault_code), 32'd0);

    // Yellow lit for only three cycles
    set_in(3'b010, 3'b001);
    tick(3);
    set_in(3'b001, 3'b001);
    tick(1);
    check_eq("short_y_pending", 32'(bus.fault), 32'd0);
    tick(1);
    check_eq("short_y_fault", 32'(bus.fault), 32'd1);
    check_eq("short_y_code", 32'(bus.fault_code), 32'd4);
    tick(3);

    do_reset("midfault");
    fault_case("dark", 3'b000, 3'b000, 3'd3);
    do_reset("r2");
    fault_case("prio_conflict", 3'b101, 3'b100, 3'd1);
    do_reset("r3");
    fault_case("multi", 3'b011, 3'b001, 3'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
